hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard unit of the 5-stage MIPS core.
- Keeps classic forwarding, load-use stalls and branch stalls.
- Adds a sequential scoreboard and latency counter for one non-pipelined multi-cycle multiply/divide (MD) unit.
- The MD unit writes the register file through a dedicated second write port. This block decides issue, tracks the pending destination, and generates D-stage RAW/WAW stalls against it.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with forwarding, load-use/branch stalls and a scoreboard for one
// non-pipelined multi-cycle MD unit. Define MD_EARLY_RELEASE_EN to release dependents and accept issue in the md_done cycle.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = $clog2(MD_LAT + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] writereg_d,
  input  logic              regwrite_d,
  input  logic              branch_d,
  input  logic              md_issue_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] writereg_w,
  input  logic              regwrite_w,
  output logic [1:0]        forwarda_e,
  output logic [1:0]        forwardb_e,
  output logic              forwarda_d,
  output logic              forwardb_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_dst
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [CNT_W-1:0]  cnt;
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_eff;
  logic [REG_AW-1:0] md_dst_q;
  logic              busy_i, done_i, busy_eff;
  logic              m_fwd_ok, w_fwd_ok, e_wr_ok, m_ld_ok;
  logic              lw_stall, br_stall, sb_stall, stall_i, start_i;
  logic              run;
  logic [1:0]        fa_e, fb_e;

  assign run    = !RST;
  assign busy_i = (cnt != '0);
  assign done_i = (cnt == CNT_W'(1));

  assign m_fwd_ok = regwrite_m && (writereg_m != '0);
  assign w_fwd_ok = regwrite_w && (writereg_w != '0);
  assign e_wr_ok  = regwrite_e && (writereg_e != '0);
  assign m_ld_ok  = memtoreg_m && (writereg_m != '0);

  assign fa_e = (m_fwd_ok && writereg_m == rs_e) ? 2'b10 :
                (w_fwd_ok && writereg_w == rs_e) ? 2'b01 : 2'b00;
  assign fb_e = (m_fwd_ok && writereg_m == rt_e) ? 2'b10 :
                (w_fwd_ok && writereg_w == rt_e) ? 2'b01 : 2'b00;

  assign lw_stall = memtoreg_e && (rt_e == rs_d || rt_e == rt_d);
  assign br_stall = branch_d &&
                    ((e_wr_ok && (writereg_e == rs_d || writereg_e == rt_d)) ||
                     (m_ld_ok && (writereg_m == rs_d || writereg_m == rt_d)));

  // With early release the completing op's pending bit and busy term are hidden in its md_done cycle.
  always_comb begin
    pend_eff = pend;
    busy_eff = busy_i;
`ifdef MD_EARLY_RELEASE_EN
    if (done_i) begin
      pend_eff[md_dst_q] = 1'b0;
      busy_eff           = 1'b0;
    end
`endif
  end

  assign sb_stall = pend_eff[rs_d] || pend_eff[rt_d] ||
                    ((regwrite_d || md_issue_d) && pend_eff[writereg_d]) ||
                    (md_issue_d && busy_eff);

  assign stall_i = lw_stall || br_stall || sb_stall;
  assign start_i = run && md_issue_d && !stall_i;

  // Issue's pending-bit set follows the completion clear so it wins on the same register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      pend     <= '0;
      md_dst_q <= '0;
    end else begin
      if (busy_i) cnt <= cnt - CNT_W'(1);
      if (done_i) pend[md_dst_q] <= 1'b0;
      if (start_i) begin
        cnt      <= CNT_W'(MD_LAT);
        md_dst_q <= writereg_d;
        if (writereg_d != '0) pend[writereg_d] <= 1'b1;
      end
    end
  end

  assign forwarda_e = run ? fa_e : '0;
  assign forwardb_e = run ? fb_e : '0;
  assign forwarda_d = run && m_fwd_ok && (writereg_m == rs_d);
  assign forwardb_d = run && m_fwd_ok && (writereg_m == rt_d);
  assign stall_f    = run && stall_i;
  assign stall_d    = run && stall_i;
  assign flush_e    = run && stall_i;
  assign md_start   = start_i;
  assign md_busy    = busy_i;
  assign md_done    = done_i;
  assign md_dst     = md_dst_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push expected output words,
// a negedge monitor pops and compares them. Honours MD_EARLY_RELEASE_EN.
module tb_hazard_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] rs_d, rt_d, writereg_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       regwrite_d, branch_d, md_issue_d, regwrite_e, memtoreg_e;
  logic       regwrite_m, memtoreg_m, regwrite_w;
  logic [1:0] forwarda_e, forwardb_e;
  logic       forwarda_d, forwardb_d, stall_f, stall_d, flush_e;
  logic       md_start, md_busy, md_done;
  logic [4:0] md_dst;

  hazard_scoreboard #(.REG_AW(5), .MD_LAT(4)) dut (
    .CLK(CLK), .RST(RST),
    .rs_d(rs_d), .rt_d(rt_d), .writereg_d(writereg_d), .regwrite_d(regwrite_d),
    .branch_d(branch_d), .md_issue_d(md_issue_d),
    .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .writereg_w(writereg_w), .regwrite_w(regwrite_w),
    .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
    .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done), .md_dst(md_dst)
  );

  always #5 CLK = ~CLK;

  logic [16:0] exp_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [16:0] act;

  assign act = {forwarda_e, forwardb_e, forwarda_d, forwardb_d, stall_f, stall_d, flush_e,
                md_start, md_busy, md_done, md_dst};

  function automatic logic [16:0] ev(input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic fad, input logic fbd, input logic st,
                                     input logic start, input logic busy, input logic done,
                                     input logic [4:0] dst);
    return {fae, fbe, fad, fbd, st, st, st, start, busy, done, dst};
  endfunction

  task automatic idle();
    rs_d = 0; rt_d = 0; writereg_d = 0; regwrite_d = 0; branch_d = 0; md_issue_d = 0;
    rs_e = 0; rt_e = 0; writereg_e = 0; regwrite_e = 0; memtoreg_e = 0;
    writereg_m = 0; regwrite_m = 0; memtoreg_m = 0; writereg_w = 0; regwrite_w = 0;
  endtask

  task automatic cyc(input string nm, input logic [16:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  initial begin : monitor
    logic [16:0] e;
    string nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %b expected %b (fae fbe fad fbd sf sd fe start busy done dst)",
                   nm, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    RST = 1'b1;
    idle();
    @(posedge CLK);
    #1;
    regwrite_m = 1; writereg_m = 8; rs_e = 8; rs_d = 8;
    cyc("reset_outputs", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    RST = 1'b0;

    idle(); regwrite_m = 1; writereg_m = 8; rs_e = 8; rt_e = 3;
    regwrite_w = 1; writereg_w = 8; rs_d = 8;
    cyc("fwd_m_priority", ev(2'b10, 2'b00, 1, 0, 0, 0, 0, 0, 0));

    idle(); regwrite_w = 1; writereg_w = 8; rs_e = 8; rt_e = 8; rs_d = 8;
    cyc("fwd_w", ev(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0));

    idle(); regwrite_m = 1; writereg_m = 0; regwrite_w = 1; writereg_w = 0;
    cyc("fwd_reg0", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    idle(); memtoreg_e = 1; rt_e = 5; rs_d = 5;
    cyc("lw_stall", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    idle(); regwrite_m = 1; memtoreg_m = 1; writereg_m = 5; rs_d = 5;
    cyc("lw_release", ev(0, 0, 1, 0, 0, 0, 0, 0, 0));

    idle(); branch_d = 1; rs_d = 9; regwrite_e = 1; writereg_e = 9;
    cyc("br_stall_e", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    idle(); branch_d = 1; rt_d = 9; regwrite_m = 1; memtoreg_m = 1; writereg_m = 9;
    cyc("br_stall_m", ev(0, 0, 0, 1, 1, 0, 0, 0, 0));
    idle(); branch_d = 1; rt_d = 9; regwrite_m = 1; writereg_m = 9;
    cyc("br_fwd_d", ev(0, 0, 0, 1, 0, 0, 0, 0, 0));
    idle(); branch_d = 1; regwrite_e = 1; writereg_e = 0;
    cyc("br_reg0", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // RAW dependency on an MD result
    idle(); md_issue_d = 1; writereg_d = 10;
    cyc("mdA_issue", ev(0, 0, 0, 0, 0, 1, 0, 0, 0));
    idle(); rs_d = 10;
    cyc("mdA_raw1", ev(0, 0, 0, 0, 1, 0, 1, 0, 10));
    cyc("mdA_raw2", ev(0, 0, 0, 0, 1, 0, 1, 0, 10));
    cyc("mdA_raw3", ev(0, 0, 0, 0, 1, 0, 1, 0, 10));
`ifdef MD_EARLY_RELEASE_EN
    cyc("mdA_done", ev(0, 0, 0, 0, 0, 0, 1, 1, 10));
`else
    cyc("mdA_done", ev(0, 0, 0, 0, 1, 0, 1, 1, 10));
`endif
    cyc("mdA_released", ev(0, 0, 0, 0, 0, 0, 0, 0, 10));

    // structural and WAW stalls
    idle(); md_issue_d = 1; writereg_d = 10;
    cyc("mdB_issue", ev(0, 0, 0, 0, 0, 1, 0, 0, 10));
    idle(); md_issue_d = 1; writereg_d = 12;
    cyc("mdB_struct1", ev(0, 0, 0, 0, 1, 0, 1, 0, 10));
    idle(); regwrite_d = 1; writereg_d = 10;
    cyc("mdB_waw", ev(0, 0, 0, 0, 1, 0, 1, 0, 10));
    idle(); md_issue_d = 1; writereg_d = 12;
    cyc("mdB_struct3", ev(0, 0, 0, 0, 1, 0, 1, 0, 10));
`ifdef MD_EARLY_RELEASE_EN
    cyc("mdB_backtoback", ev(0, 0, 0, 0, 0, 1, 1, 1, 10));
    idle();
    cyc("mdB_reloaded", ev(0, 0, 0, 0, 0, 0, 1, 0, 12));
`else
    cyc("mdB_struct4", ev(0, 0, 0, 0, 1, 0, 1, 1, 10));
    cyc("mdB_second_start", ev(0, 0, 0, 0, 0, 1, 0, 0, 10));
`endif
    idle();
    cyc("mdB_second_busy", ev(0, 0, 0, 0, 0, 0, 1, 0, 12));

    // asynchronous reset abandons the op in flight
    RST = 1'b1; rs_d = 12;
    cyc("rst_async", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    RST = 1'b0; rs_d = 12; regwrite_d = 1; writereg_d = 12;
    cyc("rst_no_pend", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    for (int i = 0; i < 4; i++) cyc("rst_no_done", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // MD op targeting register 0 occupies the unit but pends nothing
    md_issue_d = 1; writereg_d = 0;
    cyc("md0_issue", ev(0, 0, 0, 0, 0, 1, 0, 0, 0));
    idle(); regwrite_d = 1; writereg_d = 0;
    cyc("md0_no_pend", ev(0, 0, 0, 0, 0, 0, 1, 0, 0));
    idle(); md_issue_d = 1; writereg_d = 0;
    cyc("md0_struct", ev(0, 0, 0, 0, 1, 0, 1, 0, 0));
    idle();

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
